// File: rtl/inject_scheduler_if.sv
// Handshake bundle between the injection scheduler and its dataout buffers.
// The scheduler takes the slave side; the environment takes the master side.
interface inject_if #(
  parameter int NUM_BUF = 4
);
  localparam int SW = $clog2(NUM_BUF);

  logic               start;
  logic               abort;
  logic               stall;
  logic [NUM_BUF-1:0] buf_valid;
  logic [NUM_BUF-1:0] enable;
  logic [SW-1:0]      cur_sel;
  logic               busy;
  logic               all_done;
  logic [15:0]        flit_count;

  modport slave (
    input  start, abort, stall, buf_valid,
    output enable, cur_sel, busy, all_done, flit_count
  );

  modport master (
    output start, abort, stall, buf_valid,
    input  enable, cur_sel, busy, all_done, flit_count
  );
endinterface

// File: rtl/inject_scheduler.sv
// Round-robin time-slice scheduler granting enable to one dataout buffer per turn.
// Define INJECT_SCHED_STATS_EN to build the saturating flit_count statistics counter.
module inject_scheduler #(
  parameter int NUM_BUF = 4,
  parameter int DEPTH   = 30,
  parameter int SLICE   = 8,
  parameter int GAP     = 2
) (
  input  logic   clk,
  input  logic   rst,
  inject_if.slave bus
);
  localparam int SW = $clog2(NUM_BUF);
  localparam int CW = ($clog2(DEPTH + 1) > 5) ? $clog2(DEPTH + 1) : 5;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP, ST_DONE} state_t;

  state_t             state_reg, state_next;
  logic [4:0]         slice_reg;
  logic [3:0]         gap_reg;
  logic [SW-1:0]      sel_reg, sel_next;
  logic               any_open;
  logic [NUM_BUF-1:0] done_reg, done_next;
  logic [NUM_BUF-1:0] enable;

  // Per-buffer word counters; they keep counting after enable drops because
  // buffer output trails its enable by one cycle.
  generate
    for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_buf
      logic [CW-1:0] cnt_reg;
      logic          done_bit_reg;

      assign done_reg[gi]  = done_bit_reg;
      assign done_next[gi] = done_bit_reg |
                             (bus.buf_valid[gi] && (cnt_reg == CW'(DEPTH - 1)));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg      <= '0;
          done_bit_reg <= 1'b0;
        end else if (bus.buf_valid[gi] && !done_bit_reg) begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(DEPTH - 1))
            done_bit_reg <= 1'b1;
        end
      end
    end
  endgenerate

  // Next unfinished buffer after the current one; the look-ahead done bits
  // keep a buffer finishing on the last gap cycle from getting another turn.
  always_comb begin
    logic [SW-1:0] cand;
    sel_next = sel_reg;
    any_open = 1'b0;
    cand     = '0;
    for (int k = NUM_BUF; k >= 1; k--) begin
      cand = SW'((int'(sel_reg) + k) % NUM_BUF);
      if (!done_next[cand]) begin
        sel_next = cand;
        any_open = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (&done_reg)
          state_next = ST_DONE;
        else if (bus.start && !bus.abort)
          state_next = ST_RUN;
      end
      ST_RUN: begin
        if (bus.abort)
          state_next = ST_IDLE;
        else if (!bus.stall && (slice_reg == 5'(SLICE - 1)))
          state_next = ST_GAP;
      end
      ST_GAP: begin
        if (bus.abort)
          state_next = ST_IDLE;
        else if (gap_reg == 4'(GAP - 1))
          state_next = any_open ? ST_RUN : ST_DONE;
      end
      ST_DONE:  state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    enable = '0;
    if ((state_reg == ST_RUN) && !bus.stall)
      enable[sel_reg] = 1'b1;
  end

  assign bus.enable   = enable;
  assign bus.cur_sel  = sel_reg;
  assign bus.busy     = (state_reg == ST_RUN) || (state_reg == ST_GAP);
  assign bus.all_done = (state_reg == ST_DONE);

  // Slice counter restarts on every entry to RUN, including resume after abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slice_reg <= '0;
      gap_reg   <= '0;
      sel_reg   <= '0;
    end else begin
      if ((state_reg != ST_RUN) || (state_next != ST_RUN))
        slice_reg <= '0;
      else if (!bus.stall)
        slice_reg <= slice_reg + 5'd1;

      if ((state_reg == ST_GAP) && (state_next == ST_GAP))
        gap_reg <= gap_reg + 4'd1;
      else
        gap_reg <= '0;

      if ((state_reg == ST_GAP) && (state_next == ST_RUN))
        sel_reg <= sel_next;
    end
  end

`ifdef INJECT_SCHED_STATS_EN
  logic [15:0] flit_reg, flit_next;
  logic [16:0] flit_sum;

  always_comb begin
    flit_sum = {1'b0, flit_reg};
    for (int i = 0; i < NUM_BUF; i++)
      flit_sum = flit_sum + {16'd0, bus.buf_valid[i]};
    flit_next = flit_sum[16] ? 16'hFFFF : flit_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) flit_reg <= '0;
    else     flit_reg <= flit_next;
  end

  assign bus.flit_count = flit_reg;
`else
  assign bus.flit_count = '0;
`endif

endmodule

// File: tb/tb_inject_scheduler.sv
// Scoreboarded bench for inject_scheduler: expected enable grants are queued by
// the stimulus and consumed by a negedge monitor; state checks run inline.
module tb_inject_scheduler;
  localparam int NB    = 4;
  localparam int DEPTH = 30;
  localparam int SLICE = 8;
  localparam int GAP   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inject_if #(.NUM_BUF(NB)) bus();

  inject_scheduler #(
    .NUM_BUF(NB), .DEPTH(DEPTH), .SLICE(SLICE), .GAP(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Buffer models: one word per enable cycle, presented a cycle later, DEPTH max.
  logic [NB-1:0] model_valid;
  logic [NB-1:0] force_vec;
  int            issued [NB];

  assign bus.buf_valid = model_valid | force_vec;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_valid <= '0;
      for (int i = 0; i < NB; i++) issued[i] <= 0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        model_valid[i] <= bus.enable[i] && (issued[i] < DEPTH);
        if (bus.enable[i] && (issued[i] < DEPTH)) issued[i] <= issued[i] + 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int exp_q[$];

`ifdef INJECT_SCHED_STATS_EN
  localparam int FLIT_FULL = 120;
`else
  localparam int FLIT_FULL = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_turn(input int idx, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(idx);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every granted cycle must match the next queued buffer index.
  int            mon_exp;
  logic [NB-1:0] mon_en;
  always @(negedge clk) begin
    if (bus.enable !== '0) begin
      checks++;
      if ($countones(bus.enable) != 1) begin
        errors++;
        $display("FAIL onehot: got enable=%b expected one bit", bus.enable);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: got enable=%b expected none", bus.enable);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_en  = '0;
        mon_en[mon_exp] = 1'b1;
        if ((bus.enable !== mon_en) || (bus.cur_sel !== mon_exp[1:0])) begin
          errors++;
          $display("FAIL grant: got enable=%b cur_sel=%0d expected enable=%b cur_sel=%0d",
                   bus.enable, bus.cur_sel, mon_en, mon_exp);
        end
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.stall = 1'b0;
    force_vec = '0;

    repeat (2) tick();
    check("rst_enable",   bus.enable,     0);
    check("rst_busy",     bus.busy,       0);
    check("rst_all_done", bus.all_done,   0);
    check("rst_cur_sel",  bus.cur_sel,    0);
    check("rst_flit",     bus.flit_count, 0);
    rst = 1'b0;
    tick();

    // Abort on buffer 1 after four grants there.
    push_turn(0, 8);
    push_turn(1, 4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (13) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy",    bus.busy,    0);
    check("abort_enable",  bus.enable,  0);
    check("abort_cur_sel", bus.cur_sel, 1);
    check("abort_drain",   exp_q.size(), 0);
    repeat (3) tick();

    // Resume on buffer 1 with a full slice, stall buffer 2, run to completion
    // with start held high throughout.
    push_turn(1, 8); push_turn(2, 8); push_turn(3, 8); push_turn(0, 8);
    push_turn(1, 8); push_turn(2, 8); push_turn(3, 8); push_turn(0, 8);
    push_turn(1, 8); push_turn(2, 8); push_turn(3, 8); push_turn(0, 8);
    push_turn(1, 8); push_turn(2, 8); push_turn(3, 8);
    bus.start = 1'b1;
    tick();
    repeat (13) tick();
    bus.stall = 1'b1;
    #1;
    check("stall_enable", bus.enable, 0);
    check("stall_busy",   bus.busy,   1);
    repeat (5) tick();
    bus.stall = 1'b0;
    for (int n = 0; n < 2000 && !bus.all_done; n++) tick();
    check("done_reached", bus.all_done, 1);
    repeat (5) tick();
    check("done_sticky",  bus.all_done,   1);
    check("done_busy",    bus.busy,       0);
    check("done_enable",  bus.enable,     0);
    check("done_drain",   exp_q.size(),   0);
    check("done_flit",    bus.flit_count, FLIT_FULL);
    bus.start = 1'b0;

    // Reset in the middle of a slice on buffer 0.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    push_turn(0, 3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check("midrst_enable",   bus.enable,     0);
    check("midrst_busy",     bus.busy,       0);
    check("midrst_all_done", bus.all_done,   0);
    check("midrst_cur_sel",  bus.cur_sel,    0);
    check("midrst_flit",     bus.flit_count, 0);
    tick();
    rst = 1'b0;
    tick();
    check("midrst_drain", exp_q.size(), 0);

    // Buffer 3 finished early by forced valids: its turn is skipped.
    force_vec = 4'b1000;
    repeat (DEPTH) tick();
    force_vec = '0;
    tick();
    check("skip_idle_done", bus.all_done, 0);
    check("skip_idle_busy", bus.busy,     0);
    push_turn(0, 8); push_turn(1, 8); push_turn(2, 8); push_turn(0, 8);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (30) tick();
    check("skip_wrap_sel",  bus.cur_sel, 0);
    check("skip_wrap_busy", bus.busy,    1);
    repeat (8) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("gap_abort_busy", bus.busy,     0);
    check("gap_abort_sel",  bus.cur_sel,  0);
    check("skip_drain",     exp_q.size(), 0);

    // Remaining buffers fill while idle: scheduler must fall into DONE.
    force_vec = 4'b1111;
    repeat (DEPTH) tick();
    force_vec = '0;
    repeat (2) tick();
    check("idle_fill_done",   bus.all_done, 1);
    check("idle_fill_enable", bus.enable,   0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inject_scheduler.md
INJECT_SCHEDULER -- requirements
Module: inject_scheduler

Interface
REQ-001 Parameter NUM_BUF, default 4: number of dataout buffers sequenced (2..8).
REQ-002 Parameter DEPTH, default 30: words per buffer before that buffer self-terminates.
REQ-003 Parameter SLICE, default 8: enable cycles granted per turn (2..31).
REQ-004 Parameter GAP, default 2: idle cycles between turns (1..15).
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  level-sampled request to begin or resume injection.
REQ-008 abort  input  1  stop injection, return to IDLE.
REQ-009 stall  input  1  downstream backpressure; suppresses enables while high.
REQ-010 buf_valid  input  NUM_BUF  out_valid from each buffer, bit i = buffer i.
REQ-011 enable  output  NUM_BUF  one-hot-or-zero enable to buffers.
REQ-012 cur_sel  output  clog2(NUM_BUF)  index of buffer owning current turn.
REQ-013 busy  output  1  high in RUN or GAP.
REQ-014 all_done  output  1  sticky; every buffer has delivered DEPTH words.
REQ-015 flit_count  output  16  total valid words observed (see Configuration).

Function
REQ-016 States SHALL be IDLE, RUN, GAP, DONE; state, pointer and counters registered.
REQ-017 enable[cur_sel] SHALL be combinational = (state==RUN) && !stall; all other bits 0; never more than one bit high.
REQ-018 IDLE: start=1 && abort=0 -> RUN next cycle with slice counter 0; cur_sel unchanged (0 after reset).
REQ-019 RUN: slice counter increments only on cycles with stall=0; on the cycle it equals SLICE-1 with stall=0 -> GAP.
REQ-020 GAP: counts GAP cycles, enable all 0; at end selects next index after cur_sel (modulo NUM_BUF) whose done bit is clear -> RUN; if none clear -> DONE.
REQ-021 Per-buffer valid counter (5+ bits, sized to DEPTH) SHALL increment on each buf_valid[i]=1; at DEPTH, done bit i sets and counter holds.
REQ-022 buf_valid SHALL be counted in every state, including cycles after enable drops (buffer output lags enable by one cycle).
REQ-023 A RUN turn on a buffer whose done bit sets mid-slice SHALL complete its slice; extra enables are harmless.
REQ-024 abort=1 in RUN or GAP -> IDLE next cycle; enable 0 from that cycle edge; done bits and valid counters retained; cur_sel retained so start resumes at same buffer.
REQ-025 abort has priority over start; start in RUN, GAP or DONE ignored.
REQ-026 DONE: all_done=1, enable 0, busy 0; exit only by rst.
REQ-027 all_done SHALL also assert when done bits fill while in IDLE after abort: IDLE -> DONE next cycle.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, cur_sel 0, all counters and done bits 0, enable 0, busy 0, all_done 0, flit_count 0.
REQ-029 Reset mid-RUN SHALL drop enable in the same cycle without waiting for a clock edge.

Configuration
REQ-030 Macro INJECT_SCHED_STATS_EN defined: flit_count increments on each cycle by popcount(buf_valid), saturating at 16'hFFFF.
REQ-031 Macro undefined: flit_count port present, tied to 0, no counter logic.

Verification
REQ-032 Defaults, 4 buffer models, start pulse, no stall -> enable[0] 8 cycles, 2 idle, enable[1] 8 cycles ...; all_done=1 after 120 valids; with stats flit_count=120.
REQ-033 stall high 5 cycles at slice cycle 3 of buffer 2 -> enable 0 for those 5 cycles, then 5 further enable cycles on buffer 2 (8 total).
REQ-034 abort during RUN on buffer 1 -> busy 0 next cycle, enable 0; later start -> enable[1] resumes, slice counter 0, prior valid counts kept.
REQ-035 rst asserted mid-slice -> enable, busy, all_done, cur_sel, flit_count 0 immediately; subsequent start begins at buffer 0.
REQ-036 start held high through RUN and after DONE -> no restart, all_done stays 1, enable stays 0.
REQ-037 buffer 3 model pre-finished (done after 0 words issued is impossible; instead DEPTH=30 reached early via forced valids) -> GAP end skips index 3, wraps to 0.
